// File: rtl/mul_pkg.sv
// Shared types for the multiply issue path: RV32M-style op encoding, request
// record and the op-to-array-control decode helpers.
package mul_pkg;

  localparam int MUL_XLEN  = 8;
  localparam int MUL_TAG_W = 4;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef struct packed {
    mul_op_e                op;
    logic [MUL_XLEN-1:0]    srca;
    logic [MUL_XLEN-1:0]    srcb;
    logic [MUL_TAG_W-1:0]   tag;
  } mul_req_t;

  function automatic logic op_is_high(input mul_op_e op);
    return op != MUL_OP_MUL;
  endfunction

  // MULHSU runs the array unsigned and is repaired afterwards; MUL ignores sign.
  function automatic logic op_is_signed(input mul_op_e op);
    return op == MUL_OP_MULH;
  endfunction

endpackage

// File: rtl/mul_hsu_fix.sv
// MULHSU repair: the array computes the unsigned high half, so subtract srcb
// when srca is negative to obtain the signed x unsigned high half.
module mul_hsu_fix #(
  parameter int WIDTH = 8
) (
  input  logic             i_is_hsu,
  input  logic             i_srca_msb,
  input  logic [WIDTH-1:0] i_srcb,
  input  logic [WIDTH-1:0] i_result,
  output logic [WIDTH-1:0] o_result
);

  assign o_result = (i_is_hsu && i_srca_msb) ? (i_result - i_srcb) : i_result;

endmodule

// File: rtl/mul_issue_stage.sv
// Registered front-end for the external combinational array multiplier.
// Define MUL_ISSUE_OUT_REG_EN to add an s2 result register (2-cycle latency).
module mul_issue_stage
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_XLEN,
  parameter int TAG_W = MUL_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_srca,
  input  logic [WIDTH-1:0] in_srcb,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [WIDTH-1:0] mul_srca,
  output logic [WIDTH-1:0] mul_srcb,
  output logic             mul_is_mul,
  output logic             mul_is_high,
  output logic             mul_is_signed,
  input  logic [WIDTH-1:0] mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // Handshake: a transfer occurs on a rising edge where valid and ready are
  // both high; valid never waits on ready, and flush cancels every transfer
  // on its edge (in_ready is held low, the output side is simply killed).

  logic             r_s1_valid;
  mul_op_e          r_s1_op;
  logic [WIDTH-1:0] r_s1_srca;
  logic [WIDTH-1:0] r_s1_srcb;
  logic [TAG_W-1:0] r_s1_tag;

  logic             w_s1_leave;
  logic             w_accept;
  logic             w_is_hsu;
  logic [WIDTH-1:0] w_corrected;

`ifdef MUL_ISSUE_OUT_REG_EN
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;

  assign w_s1_leave = !r_s2_valid || out_ready;
`else
  assign w_s1_leave = out_ready;
`endif

  assign in_ready = !flush && (!r_s1_valid || w_s1_leave);
  assign w_accept = in_valid && in_ready;

  // Operands only move on accept, which keeps out_* stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= MUL_OP_MUL;
      r_s1_srca  <= '0;
      r_s1_srcb  <= '0;
      r_s1_tag   <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_leave) begin
        r_s1_valid <= 1'b0;
      end
      if (w_accept) begin
        r_s1_op   <= mul_op_e'(in_op);
        r_s1_srca <= in_srca;
        r_s1_srcb <= in_srcb;
        r_s1_tag  <= in_tag;
      end
    end
  end

  assign mul_srca      = r_s1_srca;
  assign mul_srcb      = r_s1_srcb;
  assign mul_is_mul    = r_s1_valid;
  assign mul_is_high   = op_is_high(r_s1_op);
  assign mul_is_signed = op_is_signed(r_s1_op);

  assign w_is_hsu = (r_s1_op == MUL_OP_MULHSU);

  mul_hsu_fix #(
    .WIDTH (WIDTH)
  ) u_hsu_fix (
    .i_is_hsu   (w_is_hsu),
    .i_srca_msb (r_s1_srca[WIDTH-1]),
    .i_srcb     (r_s1_srcb),
    .i_result   (mul_result),
    .o_result   (w_corrected)
  );

`ifdef MUL_ISSUE_OUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s1_leave) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_corrected;
        r_s2_tag    <= r_s1_tag;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;
  assign busy       = r_s1_valid || r_s2_valid;
`else
  // Gate the result so an idle stage presents zero regardless of the array.
  assign out_valid  = r_s1_valid;
  assign out_result = r_s1_valid ? w_corrected : '0;
  assign out_tag    = r_s1_tag;
  assign busy       = r_s1_valid;
`endif

endmodule

// File: tb/tb_mul_issue_stage.sv
// Self-checking bench for mul_issue_stage: directed RV32M cases, backpressure,
// flush and mid-op reset, then randomized traffic against a reference model.
module tb_mul_issue_stage;
  import mul_pkg::*;

  localparam int W  = 8;
  localparam int TW = 4;
`ifdef MUL_ISSUE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_srca;
  logic [W-1:0]  in_srcb;
  logic [TW-1:0] in_tag;
  logic          flush;
  logic [W-1:0]  mul_srca;
  logic [W-1:0]  mul_srcb;
  logic          mul_is_mul;
  logic          mul_is_high;
  logic          mul_is_signed;
  logic [W-1:0]  mul_result;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          busy;

  int n_checks = 0;
  int n_bad    = 0;
  logic [W+TW-1:0] exp_q[$];
  logic rand_rdy = 1'b0;

  mul_issue_stage #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_srca       (in_srca),
    .in_srcb       (in_srcb),
    .in_tag        (in_tag),
    .flush         (flush),
    .mul_srca      (mul_srca),
    .mul_srcb      (mul_srcb),
    .mul_is_mul    (mul_is_mul),
    .mul_is_high   (mul_is_high),
    .mul_is_signed (mul_is_signed),
    .mul_result    (mul_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_tag       (out_tag),
    .busy          (busy)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- external array multiplier (environment) ----------------
  longint prod;
  always_comb begin
    prod = mul_is_signed ? longint'($signed(mul_srca)) * longint'($signed(mul_srcb))
                         : longint'(mul_srca) * longint'(mul_srcb);
    mul_result = '0;
    if (mul_is_mul) mul_result = mul_is_high ? prod[2*W-1:W] : prod[W-1:0];
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_mul(input mul_op_e op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      MUL_OP_MUL:    p = ua * ub;
      MUL_OP_MULH:   p = (sa * sb) >>> W;
      MUL_OP_MULHSU: p = (sa * ub) >>> W;
      default:       p = (ua * ub) >>> W;
    endcase
    return p[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic            prev_stall;
    logic [W-1:0]    prev_res;
    logic [TW-1:0]   prev_tag;
    logic [W+TW-1:0] e;
    prev_stall = 1'b0;
    prev_res   = '0;
    prev_tag   = '0;
    forever begin
      @(negedge clk);
      if (rst || flush) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_vld", 32'(out_valid), 1);
          chk("hold_res", 32'(out_result), 32'(prev_res));
          chk("hold_tag", 32'(out_tag), 32'(prev_tag));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
          else begin
            e = exp_q.pop_front();
            chk("out_res", 32'(out_result), 32'(e[W-1:0]));
            chk("out_tag", 32'(out_tag), 32'(e[W+TW-1:W]));
          end
        end
        if (in_valid && in_ready)
          exp_q.push_back({in_tag, ref_mul(mul_op_e'(in_op), in_srca, in_srcb)});
        prev_stall = out_valid && !out_ready;
        prev_res   = out_result;
        prev_tag   = out_tag;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input mul_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_srca  = a;
    in_srcb  = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_single(input mul_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] tag, input logic [W-1:0] exp_res);
    out_ready = 1'b1;
    send(op, a, b, tag);
    @(negedge clk);
    chk("dir_is_mul", 32'(mul_is_mul), 1);
    chk("dir_is_high", 32'(mul_is_high), 32'(op != MUL_OP_MUL));
    chk("dir_is_signed", 32'(mul_is_signed), 32'(op == MUL_OP_MULH));
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) @(negedge clk);
      chk("dir_lat_vld", 32'(out_valid), 32'(k == LAT));
      if (k == LAT) begin
        chk("dir_res", 32'(out_result), 32'(exp_res));
        chk("dir_tag", 32'(out_tag), 32'(tag));
      end
    end
    tick();
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_result"}, 32'(out_result), 0);
    chk({tag, "_out_tag"}, 32'(out_tag), 0);
    chk({tag, "_is_mul"}, 32'(mul_is_mul), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mul_req_t r;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_srca = '0; in_srcb = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk_reset_outs("rst");
    tick();
    rst = 1'b0;

    // directed RV32M cases
    do_single(MUL_OP_MUL,    8'h03, 8'h05, 4'h3, 8'h0F);
    do_single(MUL_OP_MULH,   8'hFF, 8'hFF, 4'h5, 8'h00);
    do_single(MUL_OP_MULHU,  8'hFF, 8'hFF, 4'h6, 8'hFE);
    do_single(MUL_OP_MULHSU, 8'hFF, 8'hFF, 4'h9, 8'hFF);
    do_single(MUL_OP_MULHSU, 8'h7F, 8'h80, 4'hA, 8'h3F);

    // backpressure: two back-to-back requests, consumer stalls 3 cycles
    out_ready = 1'b0;
    send(MUL_OP_MUL, 8'h11, 8'h07, 4'h1);
    fork
      send(MUL_OP_MULHU, 8'hC3, 8'h9A, 4'h2);
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_head_vld", 32'(out_valid), 1);
        chk("bp_head_tag", 32'(out_tag), 1);
        chk("bp_head_res", 32'(out_result), 32'(8'h77));
        tick();
        out_ready = 1'b1;
      end
    join
    wait_empty("bp_drain");
    tick();

    // flush with ops in flight and a same-cycle request
    out_ready = 1'b0;
    send(MUL_OP_MULH, 8'h80, 8'h7F, 4'hB);
`ifdef MUL_ISSUE_OUT_REG_EN
    send(MUL_OP_MUL, 8'h12, 8'h34, 4'hC);
`endif
    in_valid = 1'b1; in_op = MUL_OP_MULHU; in_srca = 8'h55; in_srcb = 8'h66; in_tag = 4'hD;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 0);
    chk("flush_busy_pre", 32'(busy), 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_busy", 32'(busy), 0);
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("flush_no_emit", 32'(out_valid), 0);
    tick();

    // asynchronous reset with an op held in the stage
    out_ready = 1'b0;
    send(MUL_OP_MULHU, 8'hAB, 8'hCD, 4'hE);
    #3 rst = 1'b1;
    #1 chk_reset_outs("arst");
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("arst_lost", 32'(out_valid), 0);
    tick();
    do_single(MUL_OP_MUL, 8'h0C, 8'h0B, 4'h7, 8'h84);

    // randomized traffic with random backpressure and occasional flush
    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end else begin
        repeat ($urandom_range(0, 1)) tick();
        r.op   = mul_op_e'($urandom_range(0, 3));
        r.srca = W'($urandom);
        r.srcb = W'($urandom);
        r.tag  = TW'($urandom);
        send(r.op, r.srca, r.srcb, r.tag);
      end
    end
    rand_rdy = 1'b0;
    tick();
    out_ready = 1'b1;
    wait_empty("rand_drain");
    @(negedge clk);
    chk("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
